mlblock_seq: RTL and testbench

MLBLOCK_SEQ -- requirements
Module: mlblock_seq

---
 rtl/mlblock_seq.sv | 211 +++++++++++++++++++++
 tb/tb_mlblock_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mlblock_seq.sv
// Sequencer for a MAC block: shifts in a config word, then runs weight-load,
// accumulate and pipeline-drain phases, reporting completion with a done pulse.
module mlblock_seq #(
  parameter int unsigned CONF_LEN  = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned CFG_SEL_W = 2,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CONF_LEN-1:0]  cfg_word,
  input  logic [CFG_SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0]     w_len,
  input  logic [CNT_W-1:0]     acc_len,
  output logic [CFG_SEL_W-1:0] configg,
  output logic                 config_en,
  output logic                 config_in,
  output logic                 W_en,
  output logic                 I_en,
  output logic                 Res_en,
  output logic                 Res_cas_in_zero,
  output logic                 busy,
  output logic                 done,
  output logic                 res_valid
);

  localparam int unsigned CONF_CW = $clog2(CONF_LEN + 1);
  localparam int unsigned PIPE_CW = $clog2(PIPE_LAT + 1);
  localparam int unsigned CW0     = (CNT_W > CONF_CW) ? CNT_W : CONF_CW;
  localparam int unsigned CW      = (CW0 > PIPE_CW) ? CW0 : PIPE_CW;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_WLOAD, S_ACC, S_DRAIN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CONF_LEN-1:0]   cfg_q, cfg_d;
  logic [CNT_W-1:0]      w_len_q, w_len_d;
  logic [CNT_W-1:0]      acc_len_q, acc_len_d;
  logic [CFG_SEL_W-1:0]  configg_q, configg_d;
  logic config_en_q, config_en_d;
  logic config_in_q, config_in_d;
  logic w_en_q, w_en_d;
  logic i_en_q, i_en_d;
  logic res_en_q, res_en_d;
  logic cas_q, cas_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic res_valid_q, res_valid_d;

  // Outputs are registered from the decode of the current state, so each
  // phase shows up on the pins one cycle after the state is entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    w_len_d     = w_len_q;
    acc_len_d   = acc_len_q;
    configg_d   = configg_q;
    config_en_d = 1'b0;
    config_in_d = 1'b0;
    w_en_d      = 1'b0;
    i_en_d      = 1'b0;
    res_en_d    = 1'b0;
    cas_d       = 1'b0;
    done_d      = 1'b0;
    res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cfg_d     = cfg_word;
          w_len_d   = w_len;
          acc_len_d = acc_len;
          configg_d = cfg_sel;
          cnt_d     = CW'(CONF_LEN);
          state_d   = S_CFG;
        end
      end
      S_CFG: begin
        config_en_d = 1'b1;
        config_in_d = cfg_q[CONF_LEN-1];
        cfg_d       = cfg_q << 1;
        if (cnt_q == CW'(1)) begin
          if (w_len_q != '0) begin
            state_d = S_WLOAD;
            cnt_d   = CW'(w_len_q);
          end else if (acc_len_q != '0) begin
            state_d = S_ACC;
            cnt_d   = CW'(acc_len_q);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WLOAD: begin
        w_en_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          if (acc_len_q != '0) begin
            state_d = S_ACC;
            cnt_d   = CW'(acc_len_q);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACC: begin
        i_en_d   = 1'b1;
        res_en_d = 1'b1;
        cas_d    = (cnt_q == CW'(acc_len_q));
        if (cnt_q == CW'(1)) begin
          if (PIPE_LAT != 0) begin
            state_d = S_DRAIN;
            cnt_d   = CW'(PIPE_LAT);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        res_valid_d = (acc_len_q != '0);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end

    busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);

    // Cancel squashes every status and enable bit on the following cycle.
    if (abort) begin
      config_en_d = 1'b0;
      config_in_d = 1'b0;
      w_en_d      = 1'b0;
      i_en_d      = 1'b0;
      res_en_d    = 1'b0;
      cas_d       = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cfg_q       <= '0;
      w_len_q     <= '0;
      acc_len_q   <= '0;
      configg_q   <= '0;
      config_en_q <= 1'b0;
      config_in_q <= 1'b0;
      w_en_q      <= 1'b0;
      i_en_q      <= 1'b0;
      res_en_q    <= 1'b0;
      cas_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      w_len_q     <= w_len_d;
      acc_len_q   <= acc_len_d;
      configg_q   <= configg_d;
      config_en_q <= config_en_d;
      config_in_q <= config_in_d;
      w_en_q      <= w_en_d;
      i_en_q      <= i_en_d;
      res_en_q    <= res_en_d;
      cas_q       <= cas_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign configg         = configg_q;
  assign config_en       = config_en_q;
  assign config_in       = config_in_q;
  assign W_en            = w_en_q;
  assign I_en            = i_en_q;
  assign Res_en          = res_en_q;
  assign Res_cas_in_zero = cas_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign res_valid       = res_valid_q;

endmodule

// File: tb/tb_mlblock_seq.sv
// Scoreboard bench for mlblock_seq: directed jobs push expected summaries,
// a negedge monitor gathers the output activity and checks it at each done.
module tb_mlblock_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_word = '0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] w_len = '0;
  logic [7:0] acc_len = '0;
  logic [1:0] configg;
  logic config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero;
  logic busy, done, res_valid;

  always #5 clk = ~clk;

  mlblock_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_word(cfg_word), .cfg_sel(cfg_sel), .w_len(w_len), .acc_len(acc_len),
    .configg(configg), .config_en(config_en), .config_in(config_in),
    .W_en(W_en), .I_en(I_en), .Res_en(Res_en), .Res_cas_in_zero(Res_cas_in_zero),
    .busy(busy), .done(done), .res_valid(res_valid)
  );

  typedef struct {
    int         start_cyc;
    int         lat;
    logic [7:0] cfg;
    logic [1:0] sel;
    int         wn;
    int         an;
    int         first_i;
    logic       rv;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: accumulate activity of the running job, compare at its done pulse.
  initial begin
    logic [7:0] m_bits;
    int m_ccnt, m_wcnt, m_icnt, m_rcnt, m_cas, m_cas_bad, m_first_cfg, m_first_i;
    exp_t e;
    m_bits = '0; m_ccnt = 0; m_wcnt = 0; m_icnt = 0; m_rcnt = 0;
    m_cas = 0; m_cas_bad = 0; m_first_cfg = 0; m_first_i = 0;
    forever begin
      @(negedge clk);
      chk("enable_onehot", int'(int'(config_en) + int'(W_en) + int'(I_en) <= 1), 1);
      if (busy) begin
        if (config_en) begin
          if (m_ccnt == 0) m_first_cfg = cyc;
          m_bits = {m_bits[6:0], config_in};
          m_ccnt++;
        end
        if (W_en) m_wcnt++;
        if (I_en) begin
          if (m_icnt == 0) m_first_i = cyc;
          m_icnt++;
        end
        if (Res_en) m_rcnt++;
        if (Res_cas_in_zero) begin
          m_cas++;
          if (!(I_en && m_icnt == 1)) m_cas_bad++;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc - e.start_cyc, e.lat);
          chk("res_valid", int'(res_valid), int'(e.rv));
          chk("busy_at_done", int'(busy), 1);
          chk("configg", int'(configg), int'(e.sel));
          chk("cfg_bits", int'(m_bits), int'(e.cfg));
          chk("cfg_count", m_ccnt, 8);
          chk("cfg_first", m_first_cfg - e.start_cyc, 1);
          chk("w_count", m_wcnt, e.wn);
          chk("i_count", m_icnt, e.an);
          chk("res_count", m_rcnt, e.an);
          chk("cas_count", m_cas, (e.an != 0) ? 1 : 0);
          chk("cas_position", m_cas_bad, 0);
          if (e.an != 0) chk("first_i", m_first_i - e.start_cyc, e.first_i);
        end
      end
      if (done || !busy) begin
        m_bits = '0; m_ccnt = 0; m_wcnt = 0; m_icnt = 0; m_rcnt = 0;
        m_cas = 0; m_cas_bad = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] cw, input logic [1:0] sel, input int w,
                       input int a, input int lat, input int fi, input int hold,
                       input bit push);
    exp_t e;
    @(negedge clk);
    cfg_word = cw; cfg_sel = sel; w_len = 8'(w); acc_len = 8'(a); start = 1'b1;
    @(negedge clk);
    if (push) begin
      e.start_cyc = cyc; e.lat = lat; e.cfg = cw; e.sel = sel;
      e.wn = w; e.an = a; e.first_i = fi; e.rv = (a != 0);
      q.push_back(e);
    end
    cfg_word = 8'($urandom); cfg_sel = 2'($urandom);
    w_len = 8'($urandom); acc_len = 8'($urandom);
    if (hold > 0) repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", int'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_on_w_or_i(input bit want_i, input string nm);
    int n = 0;
    while (!(want_i ? I_en : W_en) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n < 60), 1);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("reset_outputs", int'({configg, config_en, config_in, W_en, I_en, Res_en,
                              Res_cas_in_zero, busy, done, res_valid}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // cfg A5, w=3, acc=4: done 18 cycles after the start edge
    issue(8'hA5, 2'd2, 3, 4, 18, 12, 0, 1'b1);
    wait_idle(100);
    // no weight phase, accumulate right after config
    issue(8'h3C, 2'd1, 0, 2, 13, 9, 0, 1'b1);
    wait_idle(100);
    // no accumulate: done at 14 without res_valid
    issue(8'hF0, 2'd3, 5, 0, 14, 0, 0, 1'b1);
    wait_idle(100);

    // cancel in the second accumulate cycle
    issue(8'h5A, 2'd3, 1, 4, 0, 0, 0, 1'b0);
    wait_on_w_or_i(1'b1, "abort_reach_acc");
    @(negedge clk);
    chk("abort_second_acc", int'(I_en), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_enables", int'({config_en, W_en, I_en, Res_en, Res_cas_in_zero}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'({done, res_valid}), 0);
    chk("abort_configg_hold", int'(configg), 3);
    repeat (30) @(negedge clk);
    issue(8'h81, 2'd0, 2, 3, 16, 11, 0, 1'b1);
    wait_idle(100);

    // abort beats start while idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start", int'(busy), 0);
    repeat (3) @(negedge clk);

    // start held high across the job must not launch a second one
    issue(8'h69, 2'd1, 3, 4, 18, 12, 12, 1'b1);
    wait_idle(100);

    // reset pulled low mid-cycle during the weight phase
    issue(8'hC3, 2'd2, 5, 2, 0, 0, 0, 1'b0);
    wait_on_w_or_i(1'b0, "reset_reach_wload");
    #2 reset = 1'b0;
    #1;
    chk("midjob_reset_outputs", int'({configg, config_en, config_in, W_en, I_en, Res_en,
                                     Res_cas_in_zero, busy, done, res_valid}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // longest accumulate run: 255 cycles without wrapping
    issue(8'h96, 2'd1, 2, 255, 268, 11, 0, 1'b1);
    wait_idle(400);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
